// File: rtl/mem16b_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem16b_burst_ctrl                                             |
// | Description : Burst controller in front of a 16-bit, 64K-word single-port  |
// |               memory with registered read data. Accepts burst commands     |
// |               (address, beat count, direction) over valid/ready, streams   |
// |               write beats under flow control and returns read beats as a   |
// |               valid-qualified stream without backpressure.                 |
// | Ports       : clk, rst           - clock, async active-high reset          |
// |               cmd_*              - burst command handshake                 |
// |               wr_*               - write beat stream (valid/ready)         |
// |               rd_valid, rd_data  - read beat stream                        |
// |               done, busy         - completion pulse, not-idle status       |
// |               mem_*              - memory rw/add/data_in/data_out pins     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem16b_burst_ctrl #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic          busy,
  output logic          mem_rw,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          done_q, done_d;
  logic          wr_fire;

  // Async reset forces IDLE immediately, which in turn forces mem_rw high,
  // so an interrupted write burst cannot produce a stray write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= done_d;
    end
  end

  assign wr_fire = (state_q == WRITE) && wr_valid;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_pend_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_fire) begin
          addr_d = addr_q + AW'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
      end
      READ: begin
        // One issue per cycle; the memory's registered output means each
        // beat returns one cycle later, tracked by rd_pend.
        rd_pend_d = 1'b1;
        addr_d    = addr_q + AW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          // Lines up with the last returning beat, which lands in IDLE.
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign wr_ready    = (state_q == WRITE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rd_valid    = rd_pend_q;
  assign rd_data     = mem_data_out;
  assign mem_rw      = ~wr_fire;
  assign mem_add     = addr_q;
  assign mem_data_in = wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mem16b_burst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem16b_burst_ctrl                                          |
// | Description : Self-checking bench for mem16b_burst_ctrl. Hosts a model of  |
// |               the 64K x 16 registered-output memory and a shadow array of  |
// |               expected contents; directed scenarios plus random bursts.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem16b_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        done, busy, mem_rw;
  logic [15:0] mem_add, mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] wq[$];

  mem16b_burst_ctrl #(.AW(16), .DW(16), .LW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .done         (done),
    .busy         (busy),
    .mem_rw       (mem_rw),
    .mem_add      (mem_add),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory: write on a low rw at the edge, registered read output.
  always @(posedge clk) begin
    if (!mem_rw) begin
      mem[mem_add] <= mem_data_in;
      wr_count     <= wr_count + 1;
    end
    mem_data_out <= mem[mem_add];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts on the negedge just after the accepting edge; ends in the cycle
  // in which the last beat and done are visible.
  task automatic read_body(input logic [15:0] a, input int len);
    logic [15:0] ea;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("rd_busy0", busy, 1);
    check("rd_cmd_ready0", cmd_ready, 0);
    check("rd_valid_lat", rd_valid, 0);
    check("rd_mem_rw0", mem_rw, 1);
    check("rd_mem_add0", mem_add, a);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      #1;
      ea = a + 16'(k);
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, ref_mem[ea]);
      check("rd_done", done, (k == len) ? 1 : 0);
      check("rd_mem_rw", mem_rw, 1);
      if (k < len) begin
        ea = a + 16'(k + 1);
        check("rd_mem_add", mem_add, ea);
        check("rd_busy", busy, 1);
      end else begin
        check("rd_end_busy", busy, 0);
        check("rd_end_cmd_ready", cmd_ready, 1);
      end
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int len);
    @(negedge clk);
    #1;
    check("rd_idle_done", done, 0);
    check("rd_idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    read_body(a, len);
  endtask

  // Write burst using data from wq. rnd randomises wr_valid; gap_after /
  // gap_cycles insert a fixed stall after a given beat; hold_cmd keeps a
  // read command (0x0010, one beat) offered during the burst.
  task automatic do_write(input logic [15:0] a, input int len, input bit rnd,
                          input int gap_after, input int gap_cycles, input bit hold_cmd);
    int          beat;
    int          gap_left;
    int          cycles;
    int          wc0;
    logic        v;
    logic [15:0] ea;
    beat = 0; gap_left = 0; cycles = 0;
    @(negedge clk);
    #1;
    check("wr_idle_done", done, 0);
    check("wr_idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = a;
    cmd_len   = 8'(len);
    wc0 = wr_count;
    while (beat <= len) begin
      @(negedge clk);
      if (hold_cmd) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0010;
        cmd_len   = 8'd0;
      end else begin
        cmd_valid = 1'b0;
      end
      if (gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end else if (rnd) begin
        v = ($urandom_range(0, 3) != 0);
      end else begin
        v = 1'b1;
      end
      wr_valid = v;
      wr_data  = v ? wq[beat] : 16'($urandom);
      #1;
      ea = a + 16'(beat);
      check("wr_busy", busy, 1);
      check("wr_ready", wr_ready, 1);
      check("wr_cmd_ready", cmd_ready, 0);
      check("wr_done_early", done, 0);
      check("wr_mem_rw", mem_rw, v ? 0 : 1);
      if (v) begin
        check("wr_mem_add", mem_add, ea);
        check("wr_mem_din", mem_data_in, wq[beat]);
        ref_mem[ea] = wq[beat];
        if (beat == gap_after) gap_left = gap_cycles;
        beat++;
      end
      cycles++;
      if (cycles > 1000) begin
        check("wr_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("wr_done", done, 1);
    check("wr_end_busy", busy, 0);
    check("wr_end_ready", cmd_ready, 1);
    check("wr_end_wready", wr_ready, 0);
    check("wr_end_rw", mem_rw, 1);
    check("wr_count", wr_count - wc0, len + 1);
    if (hold_cmd) read_body(16'h0010, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int wc0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_rw", mem_rw, 1);
    check("rst_mem_add", mem_add, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Gapped write then read-back.
    wq = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    do_write(16'h0010, 3, 1'b0, 1, 2, 1'b0);
    do_read(16'h0010, 3);

    // Address wrap.
    wq = '{16'h1111, 16'h2222};
    do_write(16'hFFFF, 1, 1'b0, -1, 0, 1'b0);
    do_read(16'hFFFF, 1);

    // Prefill, then a write interrupted by reset after two beats.
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back(16'($urandom));
    do_write(16'h0100, 7, 1'b1, -1, 0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_len = 8'd7;
    wc0 = wr_count;
    @(negedge clk);
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 16'h5A01;
    ref_mem[16'h0100] = 16'h5A01;
    @(negedge clk);
    wr_data = 16'h5A02;
    ref_mem[16'h0101] = 16'h5A02;
    @(negedge clk);
    wr_data = 16'h5A03;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_rw", mem_rw, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_wr_ready", wr_ready, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_mem_add", mem_add, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    check("mid_rst_wr_count", wr_count - wc0, 2);
    @(negedge clk);
    #1;
    check("mid_rst_no_done", done, 0);
    do_read(16'h0100, 7);

    // Read command held during a write burst.
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom));
    do_write(16'h0020, 3, 1'b0, -1, 0, 1'b1);

    // Random bursts in a window straddling the wrap point.
    for (int it = 0; it < 30; it++) begin
      logic [15:0] a;
      int          len;
      a   = 16'hFFF0 + 16'($urandom_range(0, 31));
      len = $urandom_range(0, 15);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_rw", mem_rw, 1);
      end
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i <= len; i++) wq.push_back(16'($urandom));
        do_write(a, len, 1'b1, -1, 0, 1'b0);
      end else begin
        do_read(a, len);
      end
    end

    @(negedge clk);
    #1;
    check("final_idle_done", done, 0);
    check("final_idle_rd_valid", rd_valid, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
